// File: rtl/alu_4_arb.sv
// Two-requester, round-robin arbitrated 4-bit ALU: grant in IDLE, compute for
// EXEC_CYCLES cycles, then hold a registered response in RESP until it is taken.
module alu_4_arb #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req1_op,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic [1:0] dbg_state
);

  // Handshakes: a request transfers in a cycle where reqN_valid && reqN_ready;
  // the response transfers in a cycle where rsp_valid && rsp_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       ptr;
  logic [2:0] cnt;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] op_q;
  logic       id_q;

  logic       any_req;
  logic       grant1;
  logic [4:0] sum;
  logic [7:0] res_d;
  logic       err_d;

  // ptr holds the last-granted requester; on contention the other one wins.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    grant1     = req1_valid & (~req0_valid | ~ptr);
    req0_ready = rst_n & (state == IDLE) & req0_valid & ~grant1;
    req1_ready = rst_n & (state == IDLE) & grant1;
    dbg_state  = state;
  end

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    res_d = 8'h00;
    err_d = 1'b0;
    case (op_q)
      4'd0:    res_d = {4'h0, a_q ^ b_q};
      4'd1:    res_d = {4'h0, a_q & b_q};
      4'd2:    res_d = {4'h0, a_q | b_q};
      4'd3:    res_d = {3'b000, sum};
      4'd4:    res_d = {4'h0, a_q} * {4'h0, b_q};
      4'd5:    res_d = {4'h0, a_q};
      4'd6:    res_d = {4'h0, b_q};
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      cnt        <= 3'd0;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      op_q       <= 4'h0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'h00;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            ptr   <= grant1;
            id_q  <= grant1;
            a_q   <= grant1 ? req1_a : req0_a;
            b_q   <= grant1 ? req1_b : req0_b;
            op_q  <= grant1 ? req1_op : req0_op;
            cnt   <= 3'(EXEC_CYCLES);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt <= 3'd1) begin
            cnt        <= 3'd0;
            rsp_result <= res_d;
            rsp_err    <= err_d;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
